// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux scan controller
// Purpose: FSM state encoding and mux select constants.
// Ports: none (package).
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - signal bundle between the scan controller and its environment
// Purpose: groups scan request, mux feedback and result signals.
// Ports (master = controller side):
//   start, cont, y      : into the controller
//   s1, s0              : mux select lines
//   word, valid, busy   : scan result and status
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       y;
  logic       s1;
  logic       s0;
  logic [3:0] word;
  logic       valid;
  logic       busy;

  modport master (
    input  start, cont, y,
    output s1, s0, word, valid, busy
  );

  modport slave (
    output start, cont, y,
    input  s1, s0, word, valid, busy
  );
endinterface

// File: rtl/mux_4x1.sv
// rtl/mux_4x1.sv - combinational 4:1 multiplexer scanned by mux_scan_ctrl
// Purpose: y selects a/b/c/d by {s1,s0} = 00/01/10/11.
// Ports: a, b, c, d (data in), s1, s0 (select), y (data out).
module mux_4x1 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic s1,
  input  logic s0,
  output logic y
);
  assign y = s1 ? (s0 ? d : c) : (s0 ? b : a);
endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sequential scanner that walks a 4:1 mux and assembles a 4-bit word
// Purpose: steps the select through a..d, waits DWELL settle cycles per channel,
//          samples y on the last cycle of each window and emits the word with a valid pulse.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : master modport (start, cont, y in; s1, s0, word, valid, busy out)
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2,
  parameter int unsigned CW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_scan_ctrl_if.master   bus
);

  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

  state_t        state_q;
  logic [1:0]    sel_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    shadow_q;
  logic [3:0]    word_q;
  logic          valid_q;
  logic          busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= SEL_A;
      cnt_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // valid is a single-cycle pulse; only the final SAMPLE re-asserts it
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= SETTLE;
            sel_q   <= SEL_A;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          // loading DWELL-1 and leaving on zero gives exactly DWELL cycles here
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (sel_q != SEL_D) begin
            shadow_q[sel_q] <= bus.y;
            sel_q           <= sel_q + 2'd1;
            cnt_q           <= CNT_LOAD;
            state_q         <= SETTLE;
          end else begin
            // channel d goes straight into the word, never through the shadow
            word_q  <= {bus.y, shadow_q};
            valid_q <= 1'b1;
            sel_q   <= SEL_A;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.cont || bus.start) begin
            state_q <= SETTLE;
            sel_q   <= SEL_A;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s1    = sel_q[1];
  assign bus.s0    = sel_q[0];
  assign bus.word  = word_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl with mux_4x1 in the loop
module tb_mux_scan_ctrl;

  typedef struct {
    logic [3:0] word;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic a0, b0, c0, d0;
  logic a1, b1, c1, d1;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  exp_t q0[$];
  exp_t q1[$];

  mux_scan_ctrl_if bus0 ();
  mux_scan_ctrl_if bus1 ();

  mux_scan_ctrl #(.DWELL(2), .CW(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux_scan_ctrl #(.DWELL(1), .CW(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  mux_4x1 u_mux0 (.a(a0), .b(b0), .c(c0), .d(d0), .s1(bus0.s1), .s0(bus0.s0), .y(bus0.y));
  mux_4x1 u_mux1 (.a(a1), .b(b1), .c(c1), .d(d1), .s1(bus1.s1), .s0(bus1.s0), .y(bus1.y));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every valid pulse must match the head of its scoreboard queue
  always @(negedge clk) begin
    exp_t e;
    if (bus0.valid === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid0: word %b at cycle %0d, none expected", bus0.word, cyc);
      end else begin
        e = q0.pop_front();
        check("word0", {28'd0, bus0.word}, {28'd0, e.word});
        check("valid_cycle0", cyc, e.cyc);
      end
    end
    if (bus1.valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid1: word %b at cycle %0d, none expected", bus1.word, cyc);
      end else begin
        e = q1.pop_front();
        check("word1", {28'd0, bus1.word}, {28'd0, e.word});
        check("valid_cycle1", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus0.start = 1'b0; bus0.cont = 1'b0;
    bus1.start = 1'b0; bus1.cont = 1'b0;
    {a0, b0, c0, d0} = 4'b0000;
    {a1, b1, c1, d1} = 4'b0000;

    // Reset with random start/cont
    for (int i = 0; i < 3; i++) begin
      bus0.start = 1'($urandom_range(0, 1));
      bus0.cont  = 1'($urandom_range(0, 1));
      bus1.start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_word", {28'd0, bus0.word}, 32'd0);
      check("rst_valid", {31'd0, bus0.valid}, 32'd0);
      check("rst_busy", {31'd0, bus0.busy}, 32'd0);
      check("rst_sel", {30'd0, bus0.s1, bus0.s0}, 32'd0);
      check("rst_busy1", {31'd0, bus1.busy}, 32'd0);
    end
    bus0.start = 1'b0; bus0.cont = 1'b0; bus1.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single scan, a..d = 0,1,1,0
    {a0, b0, c0, d0} = 4'b0110;
    bus0.start = 1'b1;
    q0.push_back('{4'b0110, cyc + 13});
    @(negedge clk);
    bus0.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check("sel_seq", {30'd0, bus0.s1, bus0.s0}, k / 3);
      check("busy_scan", {31'd0, bus0.busy}, 32'd1);
      @(negedge clk);
    end
    check("busy_done", {31'd0, bus0.busy}, 32'd0);
    check("sel_done", {30'd0, bus0.s1, bus0.s0}, 32'd0);
    repeat (4) @(negedge clk);
    check("word_hold", {28'd0, bus0.word}, 32'h6);
    check("idle_busy", {31'd0, bus0.busy}, 32'd0);

    // start held through DONE: back-to-back scans, then IDLE
    {a0, b0, c0, d0} = 4'b1111;
    bus0.start = 1'b1;
    q0.push_back('{4'b1111, cyc + 13});
    q0.push_back('{4'b1111, cyc + 26});
    repeat (14) @(negedge clk);
    bus0.start = 1'b0;
    check("rescan_busy", {31'd0, bus0.busy}, 32'd1);
    repeat (13) @(negedge clk);
    check("rescan_done_busy", {31'd0, bus0.busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("idle_after_drop", {31'd0, bus0.busy}, 32'd0);

    // Continuous mode, d flips to 1 after first valid
    {a0, b0, c0, d0} = 4'b1010;
    bus0.cont  = 1'b1;
    bus0.start = 1'b1;
    q0.push_back('{4'b0101, cyc + 13});
    q0.push_back('{4'b1101, cyc + 26});
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (12) @(negedge clk);
    d0 = 1'b1;
    @(negedge clk);
    bus0.cont = 1'b0;
    check("cont_restart_busy", {31'd0, bus0.busy}, 32'd1);
    repeat (16) @(negedge clk);
    check("cont_stop_busy", {31'd0, bus0.busy}, 32'd0);

    // Async reset while sel=2
    {a0, b0, c0, d0} = 4'b1111;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_sel", {30'd0, bus0.s1, bus0.s0}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_word", {28'd0, bus0.word}, 32'd0);
    check("async_busy", {31'd0, bus0.busy}, 32'd0);
    check("async_sel", {30'd0, bus0.s1, bus0.s0}, 32'd0);
    check("async_valid", {31'd0, bus0.valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    {a0, b0, c0, d0} = 4'b0011;
    bus0.start = 1'b1;
    q0.push_back('{4'b1100, cyc + 13});
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (15) @(negedge clk);

    // DWELL=1 instance, a..d = 1,0,0,1
    {a1, b1, c1, d1} = 4'b1001;
    bus1.start = 1'b1;
    q1.push_back('{4'b1001, cyc + 9});
    @(negedge clk);
    bus1.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("sel_seq1", {30'd0, bus1.s1, bus1.s0}, k / 2);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
